// File: rtl/gate_seq_pkg.sv
// Shared definitions for the logic-gate sequencer/checker: state encoding,
// the four-entry stimulus table and a mismatch-counting helper.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;
  localparam int ERR_W   = 4;

  // Stimulus table indexed by vector number: 0:(0,0) 1:(1,0) 2:(0,1) 3:(1,1)
  localparam logic [NUM_VEC-1:0] VEC_A = 4'b1010;
  localparam logic [NUM_VEC-1:0] VEC_B = 4'b1100;

  // Number of gate outputs (0..3) that disagree with AND/OR/NOT of the operands.
  function automatic logic [1:0] count_mismatch(
    input logic a,
    input logic b,
    input logic g_and,
    input logic g_or,
    input logic g_not
  );
    logic [1:0] n;
    n = 2'd0;
    n = n + {1'b0, (g_and != (a & b))};
    n = n + {1'b0, (g_or  != (a | b))};
    n = n + {1'b0, (g_not != ~a)};
    return n;
  endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Hold counter: counts clocks while a vector is applied and flags the last
// clock of the hold window, which is the sample point for the gate outputs.
module gate_seq_timer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority so a new vector always starts its window at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gate_seq_checker.sv
// Sequencer and self-checker for a two-input gate unit. A start request walks
// the gate through the four operand combinations, holds each for HOLD_CYCLES
// clocks, samples the gate outputs on the last held clock and accumulates the
// mismatch count, per-vector fail bitmap and a pass flag.
//
// Control semantics: iStart is a level sampled only while idle (one clock
// high is enough, extra clocks while busy are dropped, nothing is queued).
// iAbort is sampled only while holding; it returns to idle on the next edge,
// discards any sample due on that edge and suppresses the done pulse.
module gate_seq_checker
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic             iAnd,
  input  logic             iOr,
  input  logic             iNot,
  output logic             oA,
  output logic             oB,
  output logic             oBusy,
  output logic             oDone,
  output logic             oPass,
  output logic [ERR_W-1:0] oErrCnt,
  output logic [ERR_W-1:0] oErrVec
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [1:0]       idx_inc;
  logic             in_hold;
  logic             last;
  logic [1:0]       mism;
  logic             a_nxt;
  logic             b_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             pass_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;
  logic [ERR_W-1:0] err_vec_nxt;

  assign in_hold = (state == ST_HOLD);
  assign idx_inc = idx + 2'd1;
  assign mism    = count_mismatch(VEC_A[idx], VEC_B[idx], iAnd, iOr, iNot);

  gate_seq_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (iClk),
    .rst_n  (iRst_n),
    .clear  (!in_hold || last || iAbort),
    .enable (in_hold),
    .last   (last)
  );

  // State register plus the registered outputs, so no gate input reaches a port combinationally.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      oA      <= 1'b0;
      oB      <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oPass   <= 1'b0;
      oErrCnt <= '0;
      oErrVec <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      oA      <= a_nxt;
      oB      <= b_nxt;
      oBusy   <= busy_nxt;
      oDone   <= done_nxt;
      oPass   <= pass_nxt;
      oErrCnt <= err_cnt_nxt;
      oErrVec <= err_vec_nxt;
    end
  end

  // Next-state selection: abort beats the final sample, DONE always lasts one clock.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (iStart) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (iAbort) begin
          state_nxt = ST_IDLE;
        end else if (last && (idx == 2'(NUM_VEC - 1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and vector index.
  always_comb begin
    idx_nxt     = idx;
    a_nxt       = 1'b0;
    b_nxt       = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    pass_nxt    = oPass;
    err_cnt_nxt = oErrCnt;
    err_vec_nxt = oErrVec;
    case (state)
      ST_IDLE: begin
        if (iStart) begin
          idx_nxt     = 2'd0;
          a_nxt       = VEC_A[0];
          b_nxt       = VEC_B[0];
          busy_nxt    = 1'b1;
          pass_nxt    = 1'b0;
          err_cnt_nxt = '0;
          err_vec_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (iAbort) begin
          idx_nxt = 2'd0;
        end else begin
          busy_nxt = 1'b1;
          a_nxt    = VEC_A[idx];
          b_nxt    = VEC_B[idx];
          if (last) begin
            err_cnt_nxt = oErrCnt + ERR_W'(mism);
            if (mism != 2'd0) err_vec_nxt[idx] = 1'b1;
            if (idx == 2'(NUM_VEC - 1)) begin
              idx_nxt  = 2'd0;
              busy_nxt = 1'b0;
              done_nxt = 1'b1;
              a_nxt    = 1'b0;
              b_nxt    = 1'b0;
              pass_nxt = (err_cnt_nxt == '0);
            end else begin
              idx_nxt = idx_inc;
              a_nxt   = VEC_A[idx_inc];
              b_nxt   = VEC_B[idx_inc];
            end
          end
        end
      end
      default: begin
        idx_nxt = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_seq_checker.sv
// Bench for gate_seq_checker: a configurable faulty gate model, a
// position-based reference model, per-cycle comparison, a done-result
// scoreboard, directed scenarios and a randomized phase.
module tb_gate_seq_checker;

  localparam int H = 4;

  logic       iClk;
  logic       iRst_n;
  logic       iStart;
  logic       iAbort;
  logic       iAnd;
  logic       iOr;
  logic       iNot;
  logic       oA;
  logic       oB;
  logic       oBusy;
  logic       oDone;
  logic       oPass;
  logic [3:0] oErrCnt;
  logic [3:0] oErrVec;

  // Fault mask: bit 3*k+j inverts gate output j (0 AND, 1 OR, 2 NOT) while operand pair k={B,A} is applied.
  logic [11:0] flip_mask;
  logic [1:0]  ka;

  int checks = 0;
  int errors = 0;

  // Model state: m_pos 0 = idle, 1..4H = holding, 4H+1 = done cycle.
  int         m_pos = 0;
  logic       m_a = 0, m_b = 0, m_busy = 0, m_done = 0, m_pass = 0;
  logic [3:0] m_cnt = 0, m_vec = 0;
  logic [8:0] exp_q[$];

  gate_seq_checker #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iStart  (iStart),
    .iAbort  (iAbort),
    .iAnd    (iAnd),
    .iOr     (iOr),
    .iNot    (iNot),
    .oA      (oA),
    .oB      (oB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oPass   (oPass),
    .oErrCnt (oErrCnt),
    .oErrVec (oErrVec)
  );

  // Clock
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Gate under test, with injectable faults
  always_comb begin
    ka   = {oB, oA};
    iAnd = (oA & oB) ^ flip_mask[3*ka];
    iOr  = (oA | oB) ^ flip_mask[3*ka+1];
    iNot = (~oA)     ^ flip_mask[3*ka+2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: position within the run determines drive and sample points.
  always @(posedge iClk or negedge iRst_n) begin
    int k;
    int n;
    if (!iRst_n) begin
      m_pos = 0;
      m_cnt = 0;
      m_vec = 0;
      m_pass = 0;
      exp_q.delete();
    end else begin
      if (m_pos == 0) begin
        if (iStart) begin
          m_pos = 1;
          m_cnt = 0;
          m_vec = 0;
          m_pass = 0;
        end
      end else if (m_pos == 4*H+1) begin
        m_pos = 0;
      end else if (iAbort) begin
        m_pos = 0;
      end else begin
        if (m_pos % H == 0) begin
          k = m_pos / H - 1;
          n = $countones(flip_mask[3*k +: 3]);
          m_cnt = m_cnt + 4'(n);
          if (n != 0) m_vec[k] = 1'b1;
        end
        m_pos++;
        if (m_pos == 4*H+1) begin
          m_pass = (m_cnt == 0);
          exp_q.push_back({m_cnt, m_vec, m_pass});
        end
      end
    end
    m_busy = (m_pos >= 1) && (m_pos <= 4*H);
    m_done = (m_pos == 4*H+1);
    if (m_busy) begin
      k = (m_pos - 1) / H;
      m_a = k[0];
      m_b = k[1];
    end else begin
      m_a = 1'b0;
      m_b = 1'b0;
    end
  end

  // Per-cycle compare and done-result scoreboard, on the inactive edge
  always @(negedge iClk) begin
    logic [8:0] e;
    if (iRst_n) begin
      check("cycle_outputs", {oA, oB, oBusy, oDone, oPass, oErrCnt, oErrVec},
            {m_a, m_b, m_busy, m_done, m_pass, m_cnt, m_vec});
      if (oDone) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_result", {oErrCnt, oErrVec, oPass}, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge iClk);
    #2;
  endtask

  task automatic start_run();
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  // Advance until oDone (or limit edges); pulse iStart/iAbort on chosen edges after the start edge.
  task automatic wait_done(input int pulse_a, input int pulse_b, input int abort_at,
                           input int limit, output int cyc);
    cyc = 0;
    while (!oDone && cyc < limit) begin
      iStart = (cyc + 1 == pulse_a) || (cyc + 1 == pulse_b);
      iAbort = (cyc + 1 == abort_at);
      step();
      cyc++;
    end
    iStart = 1'b0;
    iAbort = 1'b0;
  endtask

  task automatic check_result(input string name, input int cyc, input int exp_cyc,
                              input logic [3:0] cnt, input logic [3:0] vec, input logic pass);
    check({name, "_done_cycle"}, cyc + 1, exp_cyc);
    check({name, "_done"}, oDone, 1);
    check({name, "_err_cnt"}, oErrCnt, cnt);
    check({name, "_err_vec"}, oErrVec, vec);
    check({name, "_pass"}, oPass, pass);
  endtask

  initial begin
    int cyc;
    iRst_n    = 1'b1;
    iStart    = 1'b0;
    iAbort    = 1'b0;
    flip_mask = 12'h000;
    #1 iRst_n = 1'b0;
    repeat (3) step();
    check("reset_outputs", {oA, oB, oBusy, oDone, oPass, oErrCnt, oErrVec}, 0);
    iRst_n = 1'b1;
    step();

    // Correct gate: full run, pass
    start_run();
    check("first_vector_ab", {oA, oB}, 2'b00);
    check("first_busy", oBusy, 1);
    wait_done(0, 0, 0, 100, cyc);
    check_result("correct", cyc, 17, 4'd0, 4'b0000, 1'b1);
    step();
    check("done_one_cycle", oDone, 0);
    check("pass_held", oPass, 1);

    // AND stuck at 0: only vector 3 fails
    flip_mask = 12'h200;
    start_run();
    wait_done(0, 0, 0, 100, cyc);
    check_result("and_stuck0", cyc, 17, 4'd1, 4'b1000, 1'b0);
    step();

    // NOT replaced by buffer: every vector fails NOT
    flip_mask = 12'h924;
    start_run();
    wait_done(0, 0, 0, 100, cyc);
    check_result("not_buffer", cyc, 17, 4'd4, 4'b1111, 1'b0);
    step();

    // Start re-pulsed mid-run is ignored; new start right after DONE clears results
    flip_mask = 12'h200;
    start_run();
    wait_done(5, 10, 0, 100, cyc);
    check_result("restart_ignored", cyc, 17, 4'd1, 4'b1000, 1'b0);
    flip_mask = 12'h000;
    step();
    start_run();
    check("restart_cleared", {oErrCnt, oErrVec, oPass}, 0);
    wait_done(0, 0, 0, 100, cyc);
    check_result("second_run", cyc + 18, 35, 4'd0, 4'b0000, 1'b1);
    step();

    // Abort during vector 1
    start_run();
    wait_done(0, 0, 6, 6, cyc);
    check("abort_state", {oA, oB, oBusy, oDone, oPass, oErrVec}, 0);
    repeat (3) begin
      step();
      check("abort_no_done", oDone, 0);
    end
    start_run();
    wait_done(0, 0, 0, 100, cyc);
    check_result("after_abort", cyc, 17, 4'd0, 4'b0000, 1'b1);
    step();

    // Asynchronous reset during vector 2
    flip_mask = 12'h924;
    start_run();
    repeat (9) step();
    #1 iRst_n = 1'b0;
    #1 check("async_reset", {oA, oB, oBusy, oDone, oPass, oErrCnt, oErrVec}, 0);
    step();
    iRst_n = 1'b1;
    flip_mask = 12'h000;
    step();
    start_run();
    wait_done(0, 0, 0, 100, cyc);
    check_result("after_reset", cyc, 17, 4'd0, 4'b0000, 1'b1);
    step();

    // Randomized phase: random starts, aborts, fault masks and rare async resets
    for (int i = 0; i < 1500; i++) begin
      iStart = ($urandom_range(0, 5) == 0);
      iAbort = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0)
        flip_mask = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 499) == 0) begin
        #1 iRst_n = 1'b0;
        #1 iRst_n = 1'b1;
      end
      step();
    end
    iStart = 1'b0;
    iAbort = 1'b0;
    repeat (30) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_seq_checker.md
Name: gate_seq_checker

Overview:
- Hardware sequencer and self-checker for the two-input logic-gate unit (ports iA, iB, oAnd, oOr, oNot).
- On a start pulse it drives the gate through all four input combinations, holding each for a fixed number of clocks.
- It samples the gate outputs at the end of each hold and compares them against expected values.
- It reports error count, per-vector fail bitmap and pass/done; this replaces manual waveform checking in bring-up.

Parameters:
HOLD_CYCLES, 4, clocks each vector is held; legal range 2..255
CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > HOLD_CYCLES

Ports:
iClk  in  1  clock, all logic on rising edge
iRst_n  in  1  asynchronous active-low reset
iStart  in  1  start request, sampled only in IDLE
iAbort  in  1  abort current run, sampled only in HOLD
iAnd  in  1  gate AND output (combinational from oA/oB)
iOr  in  1  gate OR output
iNot  in  1  gate NOT output (NOT of A)
oA  out  1  operand A to gate
oB  out  1  operand B to gate
oBusy  out  1  high while in HOLD
oDone  out  1  one-cycle pulse at normal run completion
oPass  out  1  run completed with zero errors; held until next accepted start
oErrCnt  out  4  total mismatching output bits, 0..12
oErrVec  out  4  bit k set if vector k had any mismatch

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE, idx=0, cnt=0.
  - oA, oB, oBusy, oDone, oPass=0; oErrCnt=0; oErrVec=0.
  - Takes effect immediately, including mid-run.
- Vector table (idx: A,B):
  - 0: 0,0
  - 1: 1,0
  - 2: 0,1
  - 3: 1,1
- Expected values: And=A&B, Or=A|B, Not=~A.
- States: IDLE, HOLD, DONE.
- IDLE:
  - oA=oB=0.
  - iStart=1 at an edge moves to HOLD, sets idx=0 and cnt=0, and applies vector 0.
  - The same edge clears oErrCnt, oErrVec and oPass.
- HOLD, cycle timing:
  - Start accepted at edge 0; vector k is driven during cycles k*H+1 .. (k+1)*H, where H=HOLD_CYCLES.
  - cnt increments each cycle.
  - When cnt==H-1, iAnd/iOr/iNot are compared against the expected values; mismatches count 0..3.
  - On the next edge, oErrCnt += mismatches, and oErrVec[k] is set if mismatches>0.
  - On that same edge: if idx<3, idx increments, cnt=0 and the next vector is driven; if idx==3, go to DONE.
- DONE:
  - Lasts exactly one cycle (cycle 4H+1) with oDone=1, oA=oB=0.
  - oPass=1 iff the final oErrCnt==0; it is registered on the DONE-entry edge using the updated count.
  - Next state is IDLE.
- Latency: start edge to oDone high = 4*H+1 cycles.
- oBusy=1 exactly in HOLD.
- iStart:
  - Ignored in HOLD and DONE; no queuing.
  - Back-to-back runs are possible: iStart high in the first IDLE cycle after DONE is accepted.
- iAbort:
  - In HOLD, the next edge goes to IDLE with oA=oB=0 and no oDone pulse.
  - oPass stays 0; oErrCnt/oErrVec keep partial results.
  - If the abort edge is also a sample edge, the abort wins and that sample is discarded.
  - iAbort is ignored in IDLE/DONE.
- Arithmetic: oErrCnt saturates naturally, since the maximum is 12 < 16; no wrap is possible.
- All outputs are registered; no combinational path from the gate inputs to any output.

Decomposition:
- Shared package gate_seq_pkg:
  - state encoding constants (IDLE=2'd0, HOLD=2'd1, DONE=2'd2);
  - vector table as 4-entry A/B constants;
  - NUM_VEC=4; ERR_W=4.
- Sub-module gate_seq_timer:
  - hold counter with inputs clear/enable and output last (cnt==HOLD_CYCLES-1);
  - parameterised by HOLD_CYCLES and CNT_W.
- The logic-gate unit itself is instantiated outside, by the integrating top or the bench.

Test Plan:
- Correct gate model, H=4, iStart pulse at cycle 0 -> oA/oB sequence 00,10,01,11 each for 4 cycles; oDone high at cycle 17; oPass=1, oErrCnt=0, oErrVec=4'b0000.
- AND output stuck at 0 -> only vector 3 fails; oErrCnt=1, oErrVec=4'b1000, oPass=0 at DONE.
- NOT replaced by buffer (iNot=A) -> every vector fails NOT; oErrCnt=4, oErrVec=4'b1111, oPass=0.
- iStart re-pulsed at cycles 5 and 10 during a run -> ignored, single oDone at 17; new start at cycle 18 -> second oDone at cycle 35, with results cleared at cycle 18.
- iAbort high at cycle 6 -> IDLE at 7, oA=oB=0, oBusy=0, no oDone; oErrVec=4'b0000 with a correct model; next iStart runs normally.
- iRst_n low at cycle 10 (vector 2) -> all outputs 0 immediately (asynchronous); after release, iStart gives a full correct run with oDone 17 cycles after the start edge.
